// File: rtl/pipeline_stall_controller_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer:
// FSM state encoding and default sizing.
package pipeline_stall_controller_pkg;

  typedef enum logic [1:0] {
    ST_RUN         = 2'd0,
    ST_DMEM_WAIT   = 2'd1,
    ST_MULDIV_WAIT = 2'd2,
    ST_IMEM_WAIT   = 2'd3
  } stall_state_e;

  localparam int DEFAULT_TIMEOUT_CYCLES = 255;
  localparam int DEFAULT_CNT_W          = 16;

endpackage

// File: rtl/pipeline_stall_controller_sat_counter.sv
// Saturating up-counter with synchronous clear; it stops at LIMIT
// instead of wrapping.
module sat_counter #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] LIMIT = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LIMIT)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/pipeline_stall_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: resolves memory waits,
// mul/div, taken-branch squashes and load-use hazards into hold/bubble controls.
module pipeline_stall_controller
  import pipeline_stall_controller_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int CNT_W          = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_addr1,
  input  logic [4:0]       id_addr2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_addr,
  input  logic             ex_memread,
  input  logic             branch_taken,
  input  logic             muldiv_start,
  input  logic             muldiv_done,
  input  logic             imem_busy,
  input  logic             dmem_busy,
  output logic             pc_hold,
  output logic             ifid_hold,
  output logic             ifid_flush,
  output logic             idex_hold,
  output logic             idex_bubble,
  output logic             exmem_hold,
  output logic             exmem_bubble,
  output logic             memwb_bubble,
  output logic             timeout_err,
  output logic [CNT_W-1:0] stall_count,
  output logic [1:0]       state
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES);

  stall_state_e state_q, next_state;
  logic pending_q, pending_d;
  logic err_q;
  logic muldiv_busy, load_use;
  logic pc_hold_c, ifid_hold_c, ifid_flush_c, idex_hold_c, idex_bubble_c;
  logic exmem_hold_c, exmem_bubble_c, memwb_bubble_c;
  logic [TMO_W-1:0] tmo_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RUN;
      pending_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= next_state;
      pending_q <= pending_d;
      if (tmo_count == TMO_LIMIT) begin
        err_q <= 1'b1;
      end
    end
  end

  // A branch blocked by a memory or mul/div stall is simply re-seen next
  // cycle because it is still sitting in EX, so it is acted on only once.
  always_comb begin
    next_state     = ST_RUN;
    pending_d      = pending_q;
    pc_hold_c      = 1'b0;
    ifid_hold_c    = 1'b0;
    ifid_flush_c   = 1'b0;
    idex_hold_c    = 1'b0;
    idex_bubble_c  = 1'b0;
    exmem_hold_c   = 1'b0;
    exmem_bubble_c = 1'b0;
    memwb_bubble_c = 1'b0;
    muldiv_busy = (muldiv_start || (state_q == ST_MULDIV_WAIT)) && !muldiv_done;
    load_use = ex_memread && (ex_addr != 5'd0) &&
               ((id_uses_rs1 && (id_addr1 == ex_addr)) ||
                (id_uses_rs2 && (id_addr2 == ex_addr)));

    if (dmem_busy) begin
      pc_hold_c      = 1'b1;
      ifid_hold_c    = 1'b1;
      idex_hold_c    = 1'b1;
      exmem_hold_c   = 1'b1;
      memwb_bubble_c = 1'b1;
      next_state     = ST_DMEM_WAIT;
    end else if (muldiv_busy) begin
      pc_hold_c      = 1'b1;
      ifid_hold_c    = 1'b1;
      idex_hold_c    = 1'b1;
      exmem_bubble_c = 1'b1;
      next_state     = ST_MULDIV_WAIT;
    end else begin
      if (branch_taken) begin
        ifid_flush_c  = 1'b1;
        idex_bubble_c = 1'b1;
      end else if (load_use) begin
        pc_hold_c     = 1'b1;
        ifid_hold_c   = 1'b1;
        idex_bubble_c = 1'b1;
      end else if (imem_busy) begin
        pc_hold_c    = 1'b1;
        ifid_flush_c = 1'b1;
        next_state   = ST_IMEM_WAIT;
      end
      // The wrong-path fetch lands when IMEM frees up; drop it unless IF/ID is held.
      if (pending_q && !imem_busy && !ifid_hold_c) begin
        ifid_flush_c = 1'b1;
        pending_d    = 1'b0;
      end
      if (branch_taken && imem_busy) begin
        pending_d = 1'b1;
      end
    end
  end

  assign pc_hold      = pc_hold_c      & rst_n;
  assign ifid_hold    = ifid_hold_c    & rst_n;
  assign ifid_flush   = ifid_flush_c   & rst_n;
  assign idex_hold    = idex_hold_c    & rst_n;
  assign idex_bubble  = idex_bubble_c  & rst_n;
  assign exmem_hold   = exmem_hold_c   & rst_n;
  assign exmem_bubble = exmem_bubble_c & rst_n;
  assign memwb_bubble = memwb_bubble_c & rst_n;
  assign timeout_err  = err_q;
  assign state        = state_q;

  sat_counter #(
    .WIDTH (TMO_W),
    .LIMIT (TMO_LIMIT)
  ) u_timeout_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (state_q == ST_RUN),
    .enable (state_q != ST_RUN),
    .count  (tmo_count)
  );

  sat_counter #(
    .WIDTH (CNT_W),
    .LIMIT ({CNT_W{1'b1}})
  ) u_stall_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (1'b0),
    .enable (pc_hold),
    .count  (stall_count)
  );

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed scoreboard bench for pipeline_stall_controller: each step queues
// the expected controls/state/counters and checks them mid-cycle.
module tb_pipeline_stall_controller;

  localparam int CNT_W = 5;

  localparam logic [7:0] C_NONE = 8'b0000_0000;
  localparam logic [7:0] C_DMEM = 8'b1101_0101;
  localparam logic [7:0] C_MD   = 8'b1101_0010;
  localparam logic [7:0] C_BR   = 8'b0010_1000;
  localparam logic [7:0] C_LU   = 8'b1100_1000;
  localparam logic [7:0] C_IM   = 8'b1010_0000;
  localparam logic [7:0] C_FL   = 8'b0010_0000;

  typedef struct packed {
    logic [7:0]       ctrl;
    logic [1:0]       st;
    logic [CNT_W-1:0] cnt;
    logic             err;
  } exp_t;

  logic clk, rst_n;
  logic [4:0] id_addr1, id_addr2, ex_addr;
  logic id_uses_rs1, id_uses_rs2, ex_memread, branch_taken;
  logic muldiv_start, muldiv_done, imem_busy, dmem_busy;
  logic pc_hold, ifid_hold, ifid_flush, idex_hold, idex_bubble;
  logic exmem_hold, exmem_bubble, memwb_bubble, timeout_err;
  logic [CNT_W-1:0] stall_count;
  logic [1:0] state;

  exp_t sb_q[$];
  logic [CNT_W-1:0] exp_stall;
  logic exp_err;
  int total = 0;
  int bad = 0;

  pipeline_stall_controller #(
    .TIMEOUT_CYCLES (8),
    .CNT_W          (CNT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_addr1     (id_addr1),
    .id_addr2     (id_addr2),
    .id_uses_rs1  (id_uses_rs1),
    .id_uses_rs2  (id_uses_rs2),
    .ex_addr      (ex_addr),
    .ex_memread   (ex_memread),
    .branch_taken (branch_taken),
    .muldiv_start (muldiv_start),
    .muldiv_done  (muldiv_done),
    .imem_busy    (imem_busy),
    .dmem_busy    (dmem_busy),
    .pc_hold      (pc_hold),
    .ifid_hold    (ifid_hold),
    .ifid_flush   (ifid_flush),
    .idex_hold    (idex_hold),
    .idex_bubble  (idex_bubble),
    .exmem_hold   (exmem_hold),
    .exmem_bubble (exmem_bubble),
    .memwb_bubble (memwb_bubble),
    .timeout_err  (timeout_err),
    .stall_count  (stall_count),
    .state        (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk_exp(input logic [7:0] ctrl, input int st);
    exp_t e;
    e.ctrl = ctrl;
    e.st   = 2'(st);
    e.cnt  = exp_stall;
    e.err  = exp_err;
    return e;
  endfunction

  task automatic clearInputs();
    id_addr1 = 5'd0; id_addr2 = 5'd0; ex_addr = 5'd0;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; ex_memread = 1'b0;
    branch_taken = 1'b0; muldiv_start = 1'b0; muldiv_done = 1'b0;
    imem_busy = 1'b0; dmem_busy = 1'b0;
  endtask

  task automatic checkOutput(input string tag);
    exp_t e;
    logic [7:0] obs_ctrl;
    total++;
    assert (sb_q.size() != 0) else begin
      bad++;
      $error("[TB] FAIL %s scoreboard observed=empty expected=entry", tag);
    end
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      obs_ctrl = {pc_hold, ifid_hold, ifid_flush, idex_hold,
                  idex_bubble, exmem_hold, exmem_bubble, memwb_bubble};
      total++;
      assert (obs_ctrl === e.ctrl) else begin
        bad++;
        $error("[TB] FAIL %s ctrl observed=%b expected=%b", tag, obs_ctrl, e.ctrl);
      end
      total++;
      assert (state === e.st) else begin
        bad++;
        $error("[TB] FAIL %s state observed=%0d expected=%0d", tag, state, e.st);
      end
      total++;
      assert (stall_count === e.cnt) else begin
        bad++;
        $error("[TB] FAIL %s stall_count observed=%0d expected=%0d", tag, stall_count, e.cnt);
      end
      total++;
      assert (timeout_err === e.err) else begin
        bad++;
        $error("[TB] FAIL %s timeout_err observed=%b expected=%b", tag, timeout_err, e.err);
      end
    end
  endtask

  // Inputs are driven at the falling edge; outputs are checked 1 ns later,
  // then the rising edge commits the cycle.
  task automatic applyStimulus(input string tag, input logic [7:0] ctrl, input int st);
    sb_q.push_back(mk_exp(ctrl, st));
    #1;
    checkOutput(tag);
    if (ctrl[7] && (exp_stall != {CNT_W{1'b1}})) exp_stall = exp_stall + 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    clearInputs();
    rst_n = 1'b0;
    exp_stall = '0;
    exp_err = 1'b0;
    #3;
    sb_q.push_back(mk_exp(C_NONE, 0));
    checkOutput("reset_hold");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus("idle", C_NONE, 0);

    ex_memread = 1'b1; ex_addr = 5'd5; id_addr1 = 5'd5; id_uses_rs1 = 1'b1;
    applyStimulus("lu_rs1", C_LU, 0);
    ex_memread = 1'b0;
    applyStimulus("lu_clear", C_NONE, 0);
    ex_memread = 1'b1; ex_addr = 5'd0; id_addr1 = 5'd0;
    applyStimulus("lu_x0", C_NONE, 0);
    ex_addr = 5'd7; id_addr1 = 5'd3; id_addr2 = 5'd7;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b1;
    applyStimulus("lu_rs2", C_LU, 0);
    id_uses_rs2 = 1'b0;
    applyStimulus("lu_no_use", C_NONE, 0);
    clearInputs();

    dmem_busy = 1'b1; branch_taken = 1'b1;
    applyStimulus("dmem_c1", C_DMEM, 0);
    applyStimulus("dmem_c2", C_DMEM, 1);
    applyStimulus("dmem_c3", C_DMEM, 1);
    dmem_busy = 1'b0;
    applyStimulus("dmem_br", C_BR, 1);
    branch_taken = 1'b0;
    applyStimulus("dmem_after", C_NONE, 0);

    muldiv_start = 1'b1;
    applyStimulus("md_t0", C_MD, 0);
    muldiv_start = 1'b0;
    for (int i = 1; i <= 3; i++) applyStimulus($sformatf("md_t%0d", i), C_MD, 2);
    muldiv_done = 1'b1;
    applyStimulus("md_t4", C_NONE, 2);
    muldiv_done = 1'b0;
    applyStimulus("md_t5", C_NONE, 0);
    muldiv_start = 1'b1; muldiv_done = 1'b1;
    applyStimulus("md_same", C_NONE, 0);
    muldiv_start = 1'b0; muldiv_done = 1'b0;
    applyStimulus("md_same_after", C_NONE, 0);

    branch_taken = 1'b1; imem_busy = 1'b1;
    applyStimulus("pf_branch", C_BR, 0);
    branch_taken = 1'b0;
    applyStimulus("pf_imem", C_IM, 0);
    imem_busy = 1'b0;
    applyStimulus("pf_release", C_FL, 3);
    applyStimulus("pf_done", C_NONE, 0);
    branch_taken = 1'b1;
    applyStimulus("br_plain", C_BR, 0);
    branch_taken = 1'b0;
    applyStimulus("br_plain_after", C_NONE, 0);

    ex_memread = 1'b1; ex_addr = 5'd9; id_addr1 = 5'd9; id_uses_rs1 = 1'b1;
    imem_busy = 1'b1;
    applyStimulus("lu_over_imem", C_LU, 0);
    clearInputs();
    applyStimulus("lu_over_imem_after", C_NONE, 0);

    dmem_busy = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      if (i == 11) exp_err = 1'b1;
      applyStimulus($sformatf("tmo_c%0d", i), C_DMEM, (i == 1) ? 0 : 1);
    end
    dmem_busy = 1'b0;
    applyStimulus("tmo_release", C_NONE, 1);
    applyStimulus("tmo_sticky", C_NONE, 0);

    imem_busy = 1'b1;
    for (int i = 1; i <= 12; i++) applyStimulus($sformatf("sat_c%0d", i), C_IM, (i == 1) ? 0 : 3);
    imem_busy = 1'b0;
    applyStimulus("sat_release", C_NONE, 3);

    muldiv_start = 1'b1;
    applyStimulus("rst_md0", C_MD, 0);
    muldiv_start = 1'b0;
    applyStimulus("rst_md1", C_MD, 2);
    dmem_busy = 1'b1;
    #2;
    rst_n = 1'b0;
    exp_stall = '0;
    exp_err = 1'b0;
    sb_q.push_back(mk_exp(C_NONE, 0));
    #1;
    checkOutput("rst_mid");
    @(negedge clk);
    clearInputs();
    rst_n = 1'b1;
    ex_memread = 1'b1; ex_addr = 5'd5; id_addr1 = 5'd5; id_uses_rs1 = 1'b1;
    applyStimulus("post_rst_lu", C_LU, 0);
    clearInputs();
    applyStimulus("post_rst_idle", C_NONE, 0);

    total++;
    assert (sb_q.size() == 0) else begin
      bad++;
      $error("[TB] FAIL sb_drain observed=%0d expected=0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
